key_debounce: RTL and testbench

- Input-side companion to the LED output logic: reads N raw pushbuttons or switches from board pins.
- Synchronizes each input into `clk` and debounces it against a slow sample tick derived from `clk`.
- Produces clean per-key levels, one-cycle press/release pulses, and an encoded key index.
- Downstream control logic (LED pattern select, mode change) consumes the pulses instead of raw pins.

---
 rtl/key_debounce_pkg.sv | 9 +
 rtl/key_debounce_cell.sv | 62 ++++++
 rtl/key_debounce.sv | 88 ++++++++
 tb/tb_key_debounce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared helpers for the key debouncer: counter width sizing.
package key_debounce_pkg;

  // Width of a counter that must hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key's debounce state: accepts a level after STABLE_SAMPLES differing ticks.
// Latency: pulse registered with the state flip on the accepting tick; no backpressure.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_sync,
  output logic state,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = cnt_width(STABLE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      if (key_sync == state_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        state_d   = key_sync;
        cnt_d     = '0;
        press_d   = key_sync;
        release_d = ~key_sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state         = state_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/key_debounce.sv
// Synchronizes and debounces NUM_KEYS raw pins; emits levels, press/release pulses, key code.
// Latency: 2 sync cycles + up to STABLE_SAMPLES ticks + 1; no backpressure (pulses are fire-and-forget).
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS       = 8,
  parameter int TICK_CYCLES    = 1000000,
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_LOW     = 1,
  parameter int CODE_W         = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code
);

  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("key_debounce: TICK_CYCLES must be >= 2");
  end
  if (STABLE_SAMPLES < 1) begin : g_bad_stable
    $error("key_debounce: STABLE_SAMPLES must be >= 1");
  end
  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_pol
    $error("key_debounce: ACTIVE_LOW must be 0 or 1");
  end
  if ((1 << CODE_W) < NUM_KEYS) begin : g_bad_code
    $error("key_debounce: CODE_W too narrow for NUM_KEYS");
  end

  localparam int              TICK_W    = cnt_width(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic            POL       = (ACTIVE_LOW != 0);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tick;

  assign tick = (tick_cnt_q == TICK_LAST);

  // Polarity is folded in before the first flop so reset value 0 means released.
  always_comb begin
    sync1_d    = key_in ^ {NUM_KEYS{POL}};
    sync2_d    = sync1_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cell
    key_debounce_cell #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .key_sync     (sync2_q[i]),
      .state        (key_state[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i])
    );
  end

  // Decoded straight from the registered press vector so valid/code align with the pulse.
  always_comb begin
    key_valid = |key_press;
    key_code  = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_press[i]) key_code = CODE_W'(i);
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bouncing, checked every cycle against a sample-history model.
module tb_key_debounce;

  localparam int NK = 8;
  localparam int TC = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in    = 8'hFF;
  logic [NK-1:0] key_in_hi = 8'h00;

  logic [NK-1:0] st_lo, pr_lo, rl_lo, st_hi, pr_hi, rl_hi;
  logic          vl_lo, vl_hi;
  logic [2:0]    cd_lo, cd_hi;

  always #5 clk = ~clk;

  key_debounce #(.NUM_KEYS(NK), .TICK_CYCLES(TC), .STABLE_SAMPLES(SS), .ACTIVE_LOW(1), .CODE_W(3)) dut_lo (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(st_lo), .key_press(pr_lo),
    .key_release(rl_lo), .key_valid(vl_lo), .key_code(cd_lo));

  key_debounce #(.NUM_KEYS(NK), .TICK_CYCLES(TC), .STABLE_SAMPLES(SS), .ACTIVE_LOW(0), .CODE_W(3)) dut_hi (
    .clk(clk), .rst(rst), .key_in(key_in_hi), .key_state(st_hi), .key_press(pr_hi),
    .key_release(rl_hi), .key_valid(vl_hi), .key_code(cd_hi));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: per key, a history of tick samples; a level is accepted once the
  // most recent SS samples all disagree with the current level.
  logic [NK-1:0] m_s1[2], m_s2[2], m_lvl[2], m_press[2], m_rel[2];
  int            m_cyc[2];
  logic [31:0]   hist[2][NK];
  int            nsamp[2][NK];

  function automatic int run_len(input int d, input int k);
    int n = 0;
    while (n < nsamp[d][k] && n < 32 && hist[d][k][n] != m_lvl[d][k]) n++;
    return n;
  endfunction

  function automatic logic [2:0] lowest(input logic [NK-1:0] v);
    logic [2:0] r = 3'd0;
    for (int i = NK - 1; i >= 0; i--) if (v[i]) r = 3'(i);
    return r;
  endfunction

  task automatic model_step(input int d, input logic r, input logic [NK-1:0] raw);
    if (r) begin
      m_s1[d] = '0; m_s2[d] = '0; m_lvl[d] = '0; m_press[d] = '0; m_rel[d] = '0; m_cyc[d] = 0;
      for (int k = 0; k < NK; k++) begin hist[d][k] = '0; nsamp[d][k] = 0; end
    end else begin
      m_press[d] = '0; m_rel[d] = '0;
      if ((m_cyc[d] % TC) == TC - 1) begin
        for (int k = 0; k < NK; k++) begin
          hist[d][k] = {hist[d][k][30:0], m_s2[d][k]};
          if (nsamp[d][k] < 32) nsamp[d][k]++;
          if (run_len(d, k) >= SS) begin
            m_lvl[d][k] = ~m_lvl[d][k];
            if (m_lvl[d][k]) m_press[d][k] = 1'b1; else m_rel[d][k] = 1'b1;
            hist[d][k] = '0; nsamp[d][k] = 0;
          end
        end
      end
      m_s2[d] = m_s1[d];
      m_s1[d] = raw;
      m_cyc[d]++;
    end
  endtask

  int            gcyc = 0;
  int            pcnt[2], rcnt[2], press_cyc[2];
  logic [NK-1:0] last_press[2], last_rel[2];
  logic          last_valid[2], rel_valid[2];
  logic [2:0]    last_code[2];

  task automatic clear_acc();
    for (int d = 0; d < 2; d++) begin
      pcnt[d] = 0; rcnt[d] = 0; press_cyc[d] = -1;
      last_press[d] = '0; last_rel[d] = '0; last_valid[d] = 1'b0; rel_valid[d] = 1'b1; last_code[d] = 3'd7;
    end
  endtask

  // Per-cycle compare against the model, plus event capture for the directed checks.
  initial begin
    logic          rs;
    logic [NK-1:0] raw[2], gs[2], gp[2], gr[2];
    logic          gv[2];
    logic [2:0]    gc[2];
    forever begin
      @(posedge clk);
      rs = rst; raw[0] = ~key_in; raw[1] = key_in_hi;
      #1;
      gcyc++;
      gs[0] = st_lo; gp[0] = pr_lo; gr[0] = rl_lo; gv[0] = vl_lo; gc[0] = cd_lo;
      gs[1] = st_hi; gp[1] = pr_hi; gr[1] = rl_hi; gv[1] = vl_hi; gc[1] = cd_hi;
      for (int d = 0; d < 2; d++) begin
        model_step(d, rs, raw[d]);
        chk($sformatf("state[%0d]", d),   32'(gs[d]), 32'(m_lvl[d]));
        chk($sformatf("press[%0d]", d),   32'(gp[d]), 32'(m_press[d]));
        chk($sformatf("release[%0d]", d), 32'(gr[d]), 32'(m_rel[d]));
        chk($sformatf("valid[%0d]", d),   32'(gv[d]), 32'(|m_press[d]));
        chk($sformatf("code[%0d]", d),    32'(gc[d]), 32'(lowest(m_press[d])));
        if (gp[d] != '0) begin
          pcnt[d]++; last_press[d] = gp[d]; last_valid[d] = gv[d]; last_code[d] = gc[d];
          if (press_cyc[d] < 0) press_cyc[d] = gcyc;
        end
        if (gr[d] != '0) begin
          rcnt[d]++; last_rel[d] = gr[d]; rel_valid[d] = gv[d];
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int t0, rcyc, w;
    bit quiet;
    clear_acc();

    // Reset held with pins idle (active-low idle = 1).
    cyc(3);
    chk("rst_state", 32'(st_lo), 32'h0);
    chk("rst_press", 32'(pr_lo), 32'h0);
    chk("rst_valid", 32'(vl_lo), 32'h0);
    chk("rst_code",  32'(cd_lo), 32'h0);
    rst = 1'b0;
    clear_acc();
    cyc(50);
    chk("idle_presses",  32'(pcnt[0] + pcnt[1]), 32'd0);
    chk("idle_releases", 32'(rcnt[0] + rcnt[1]), 32'd0);

    // Clean press and release of key 2.
    clear_acc(); t0 = gcyc;
    key_in[2] = 1'b0;
    cyc(20);
    chk("k2_press_cnt", 32'(pcnt[0]), 32'd1);
    chk("k2_press_vec", 32'(last_press[0]), 32'h04);
    chk("k2_valid",     32'(last_valid[0]), 32'd1);
    chk("k2_code",      32'(last_code[0]), 32'd2);
    chk("k2_latency_le15", 32'((press_cyc[0] - t0) <= 15), 32'd1);
    chk("k2_state",     32'(st_lo), 32'h04);
    clear_acc();
    key_in[2] = 1'b1;
    cyc(20);
    chk("k2_rel_cnt",   32'(rcnt[0]), 32'd1);
    chk("k2_rel_vec",   32'(last_rel[0]), 32'h04);
    chk("k2_rel_valid", 32'(rel_valid[0]), 32'd0);
    chk("k2_rel_state", 32'(st_lo), 32'h00);

    // Bounce on key 5: toggle every 3 cycles for 60 cycles.
    clear_acc();
    for (int i = 0; i < 20; i++) begin
      key_in[5] = ~key_in[5];
      cyc(3);
    end
    cyc(20);
    chk("bounce_presses", 32'(pcnt[0]), 32'd0);
    chk("bounce_state5",  32'(st_lo[5]), 32'd0);
    key_in[5] = 1'b0;
    cyc(20);
    chk("bounce_then_hold", 32'(pcnt[0]), 32'd1);
    chk("k5_press_vec",     32'(last_press[0]), 32'h20);

    // Simultaneous presses of keys 1 and 6.
    clear_acc();
    key_in[1] = 1'b0; key_in[6] = 1'b0;
    cyc(20);
    chk("sim_press_cycles", 32'(pcnt[0]), 32'd1);
    chk("sim_press_vec",    32'(last_press[0]), 32'h42);
    chk("sim_code",         32'(last_code[0]), 32'd1);
    chk("sim_valid",        32'(last_valid[0]), 32'd1);
    key_in = 8'hFF;
    cyc(20);
    chk("all_released", 32'(st_lo), 32'h00);

    // Reset after two accepted samples of key 3; the count must restart.
    clear_acc();
    key_in[3] = 1'b0;
    w = 0;
    while (run_len(0, 3) < 2 && w < 40) begin cyc(1); w++; end
    chk("k3_two_samples_reached", 32'(run_len(0, 3)), 32'd2);
    chk("k3_no_early_press", 32'(pcnt[0]), 32'd0);
    rst = 1'b1; rcyc = gcyc + 1;
    clear_acc();
    cyc(1);
    rst = 1'b0;
    cyc(25);
    chk("k3_press_cnt",  32'(pcnt[0]), 32'd1);
    chk("k3_press_vec",  32'(last_press[0]), 32'h08);
    chk("k3_code",       32'(last_code[0]), 32'd3);
    chk("k3_post_rst_delay", 32'(press_cyc[0] - rcyc), 32'd12);
    key_in[3] = 1'b1;
    cyc(20);

    // Active-high instance, key 0.
    clear_acc();
    key_in_hi[0] = 1'b1;
    cyc(20);
    chk("hi_press_cnt", 32'(pcnt[1]), 32'd1);
    chk("hi_press_vec", 32'(last_press[1]), 32'h01);
    chk("hi_code",      32'(last_code[1]), 32'd0);
    chk("hi_valid",     32'(last_valid[1]), 32'd1);
    clear_acc();
    key_in_hi[0] = 1'b0;
    cyc(20);
    chk("hi_rel_cnt", 32'(rcnt[1]), 32'd1);
    chk("hi_rel_vec", 32'(last_rel[1]), 32'h01);

    // Random bouncing with quiet stretches and occasional resets.
    quiet = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i % 150 == 0) quiet = ($urandom_range(1) == 1);
      if ($urandom_range(quiet ? 63 : 3) == 0) key_in[$urandom_range(NK - 1)] ^= 1'b1;
      if ($urandom_range(quiet ? 63 : 3) == 0) key_in_hi[$urandom_range(NK - 1)] ^= 1'b1;
      rst = ($urandom_range(499) == 0);
    end
    rst = 1'b0;
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
